// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide engine for the EXE stage. It produces a
//   {hi, lo} pair for the HI/LO register path. The operations are:
//     mult / multu : out_hi:out_lo = full 2*WIDTH product (signed / unsigned)
//     div  / divu  : out_lo = quotient, out_hi = remainder
//
//   Handshake:
//     in_valid/in_ready   - A request is taken on a clk edge where
//                           in_valid & in_ready & (op != 0) & ~cancel.
//                           in_ready is high only while the unit is IDLE.
//     out_valid/out_ready - The result is transferred on a clk edge where
//                           out_valid & out_ready. The result outputs stay
//                           stable until that edge. in_ready rises on the
//                           next cycle.
//     cancel              - Flushes whatever is in flight on the next edge.
//                           Cancel wins over both the input handshake and
//                           the output handshake.
//
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     in_valid, in_ready   request handshake
//     op[3:0]              one-hot {divu, div, multu, mult}
//                          priority mult > multu > div > divu
//     src1, src2           multiplicand/dividend, multiplier/divisor
//     cancel               exception flush
//     out_valid, out_ready result handshake
//     out_hi, out_lo       product high/low, or remainder/quotient
//     div_by_zero          qualifies out_valid for a divide by zero
//     busy                 unit is not IDLE
//
//   Build option:
//     MULDIV_EARLY_OUT_EN  When defined, a divide with |dividend| < |divisor|
//                          skips the iteration and finishes 2 edges after
//                          acceptance.
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_hi,
  output logic [WIDTH-1:0] out_lo,
  output logic             div_by_zero,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // A single counter sequences both the multiply wait and the divide phases.
  localparam int CW = $clog2(WIDTH + MUL_STAGES + 2) + 1;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             op_signed;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_hi_r;
  logic [WIDTH-1:0] out_lo_r;
  logic             dbz_r;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic sel_mul;
  logic sel_signed;

  assign accept = in_valid & (state == S_IDLE) & (op != 4'b0000) & ~cancel;

  always_comb begin
    sel_mul    = 1'b0;
    sel_signed = 1'b0;
    if (op[0]) begin
      sel_mul    = 1'b1;
      sel_signed = 1'b1;
    end else if (op[1]) begin
      sel_mul    = 1'b1;
    end else if (op[2]) begin
      sel_signed = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier
  // The operands are held in a_reg/b_reg for the whole MUL state. The product
  // is therefore a multicycle path of MUL_STAGES cycles. Both operands are
  // extended to 2*WIDTH bits, so one unsigned multiply truncated to 2*WIDTH
  // bits gives the correct result for both the signed and unsigned cases.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] product;

  assign mul_a   = op_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg}
                             : {{WIDTH{1'b0}}, a_reg};
  assign mul_b   = op_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg}
                             : {{WIDTH{1'b0}}, b_reg};
  assign product = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Divider datapath
  // The divider works on magnitudes. MIN has no positive counterpart, but
  // |MIN| read as unsigned is 2^(WIDTH-1). So MIN / -1 comes out as
  // quotient 2^(WIDTH-1) with no negation, which is MIN with remainder 0.
  // This is the defined overflow result, and it needs no special case.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign a_abs = (op_signed & a_reg[WIDTH-1]) ? (~a_reg + 1'b1) : a_reg;
  assign b_abs = (op_signed & b_reg[WIDTH-1]) ? (~b_reg + 1'b1) : b_reg;

  // One restoring step: shift the next dividend bit into the partial
  // remainder, then try to subtract the divisor. trial[WIDTH] set = borrow.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs};

  // Sign fixup: the quotient truncates toward zero, and the remainder takes
  // the sign of the dividend.
  assign q_fix = neg_q ? (~quo + 1'b1) : quo;
  assign r_fix = neg_r ? (~rem + 1'b1) : rem;

  // ---------------------------------------------------------------------------
  // Control FSM
  // DIV phases by cnt:
  //   0           - zero check, take magnitudes
  //   1..WIDTH    - one quotient bit per edge
  //   WIDTH+1     - sign fixup and result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_signed   <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_valid_r <= 1'b0;
      out_hi_r    <= '0;
      out_lo_r    <= '0;
      dbz_r       <= 1'b0;
    end else if (cancel) begin
      // Drop any operation. out_hi/out_lo keep their last delivered value.
      state       <= S_IDLE;
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg     <= src1;
            b_reg     <= src2;
            op_signed <= sel_signed;
            cnt       <= '0;
            state     <= sel_mul ? S_MUL : S_DIV;
          end
        end

        S_MUL: begin
          if (cnt == CW'(MUL_STAGES - 1)) begin
            out_hi_r    <= product[2*WIDTH-1:WIDTH];
            out_lo_r    <= product[WIDTH-1:0];
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_DIV: begin
          if (cnt == '0) begin
            if (b_reg == '0) begin
              out_lo_r    <= '1;
              out_hi_r    <= a_reg;
              dbz_r       <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= S_DONE;
            end else begin
              dvs   <= b_abs;
              neg_q <= op_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
              neg_r <= op_signed & a_reg[WIDTH-1];
              if (EARLY_OUT && (a_abs < b_abs)) begin
                // The quotient is 0 and the remainder is the whole dividend.
                // Jump straight to the fixup phase.
                rem <= a_abs;
                quo <= '0;
                cnt <= CW'(WIDTH + 1);
              end else begin
                rem <= '0;
                quo <= a_abs;
                cnt <= CW'(1);
              end
            end
          end else if (cnt == CW'(WIDTH + 1)) begin
            out_lo_r    <= q_fix;
            out_hi_r    <= r_fix;
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end else begin
            if (trial[WIDTH]) begin
              rem <= rem_shift[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b0};
            end else begin
              rem <= trial[WIDTH-1:0];
              quo <= {quo[WIDTH-2:0], 1'b1};
            end
            cnt <= cnt + CW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign out_valid   = out_valid_r;
  assign out_hi      = out_hi_r;
  assign out_lo      = out_lo_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//   Bench for muldiv_unit with WIDTH=32 and MUL_STAGES=2. Each scenario task
//   pushes its expected {hi, lo, div_by_zero, latency} onto the scoreboard
//   queues when it drives a request. collect() pops the entry and compares
//   it when the DUT presents the result. Latency is counted in clk edges
//   from the accept edge. Set MULDIV_EARLY_OUT_EN the same way as for the
//   RTL build.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         cancel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_hi;
  logic [W-1:0] out_lo;
  logic         div_by_zero;
  logic         busy;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .cancel      (cancel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_hi      (out_hi),
    .out_lo      (out_lo),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_hi_q[$];
  logic [W-1:0] exp_lo_q[$];
  logic         exp_dbz_q[$];
  int           exp_lat_q[$];

  task automatic expect_res(input logic [W-1:0] hi, input logic [W-1:0] lo,
                            input logic dbz, input int lat);
    exp_hi_q.push_back(hi);
    exp_lo_q.push_back(lo);
    exp_dbz_q.push_back(dbz);
    exp_lat_q.push_back(lat);
  endtask

  // Reference model for the random ops. It uses the language's own division
  // (truncating, remainder follows the dividend). The cases that division
  // leaves undefined are spelled out separately.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] hi,
                                output logic [W-1:0] lo, output logic dbz,
                                output int lat);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    logic [W-1:0] aa;
    logic [W-1:0] ab;
    dbz = 1'b0;
    if (o[0]) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      hi = sp[63:32]; lo = sp[31:0]; lat = 2;
    end else if (o[1]) begin
      up = {32'h0, a} * {32'h0, b};
      hi = up[63:32]; lo = up[31:0]; lat = 2;
    end else if (b == '0) begin
      hi = a; lo = '1; dbz = 1'b1; lat = 1;
    end else if (o[2]) begin
      sa = a; sb = b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        lo = a; hi = '0;
      end else begin
        lo = sa / sb; hi = sa % sb;
      end
      aa = a[31] ? -a : a;
      ab = b[31] ? -b : b;
      lat = (EARLY && aa < ab) ? 2 : 34;
    end else begin
      lo = a / b; hi = a % b;
      lat = (EARLY && a < b) ? 2 : 34;
    end
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1. Returns at posedge+1 after the accept edge, with the
  // inputs scrambled so that any operand latching bug shows up.
  task automatic drive(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; op = o; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom_range(1, 15));
    src1 = $urandom; src2 = $urandom;
  endtask

  // Waits for out_valid, then compares the result against the queue head.
  // It can hold out_ready low for a number of cycles first, then completes
  // the handshake.
  task automatic collect(input string name, input int hold);
    logic [W-1:0] eh;
    logic [W-1:0] el;
    logic         ed;
    int           elat;
    int           lat;
    logic [W-1:0] sh;
    logic [W-1:0] sl;
    n_checks++;
    if (exp_hi_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: scoreboard empty, got nothing to compare, required an entry", name);
      return;
    end
    eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
    ed = exp_dbz_q.pop_front(); elat = exp_lat_q.pop_front();
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL %s busy: busy=%b in_ready=%b, required 1/0", name, busy, in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== elat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d edges, required %0d", name, lat, elat);
    end
    n_checks++;
    if (out_hi !== eh || out_lo !== el || div_by_zero !== ed) begin
      n_errors++;
      $display("FAIL %s result: hi=%h lo=%h dbz=%b, required hi=%h lo=%h dbz=%b",
               name, out_hi, out_lo, div_by_zero, eh, el, ed);
    end
    sh = out_hi; sl = out_lo;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_hi !== sh || out_lo !== sl || in_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL %s hold%0d: valid=%b hi=%h lo=%h in_ready=%b, required 1 %h %h 0",
                 name, i, out_valid, out_hi, out_lo, in_ready, sh, sl);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || div_by_zero !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s release: valid=%b dbz=%b in_ready=%b, required 0 0 1",
               name, out_valid, div_by_zero, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; op = '0; src1 = '0; src2 = '0;
    cancel = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        div_by_zero !== 1'b0 || out_hi !== '0 || out_lo !== '0) begin
      n_errors++;
      $display("FAIL reset: in_ready=%b valid=%b busy=%b dbz=%b hi=%h lo=%h, required 1 0 0 0 0 0",
               in_ready, out_valid, busy, div_by_zero, out_hi, out_lo);
    end
  endtask

  task automatic test_mul();
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 2);
    drive(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    collect("mult", 0);
    expect_res(32'h0000_0002, 32'hFFFF_FFFA, 1'b0, 2);
    drive(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    collect("multu", 0);
  endtask

  task automatic test_div();
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    collect("div_neg", 0);
    expect_res(32'h0000_0001, 32'h0000_0003, 1'b0, 34);
    drive(OP_DIVU, 32'd7, 32'd2);
    collect("divu", 0);
    expect_res(32'h0000_0000, 32'h8000_0000, 1'b0, 34);
    drive(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    collect("div_ovf", 0);
    expect_res(32'h0000_0005, 32'hFFFF_FFFF, 1'b1, 1);
    drive(OP_DIVU, 32'd5, 32'd0);
    collect("divu_zero", 0);
    expect_res(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1);
    drive(OP_DIV, 32'hFFFF_FFFB, 32'd0);
    collect("div_zero", 0);
    expect_res(32'h0000_0003, 32'h0000_0000, 1'b0, EARLY ? 2 : 34);
    drive(OP_DIVU, 32'd3, 32'd9);
    collect("divu_small", 0);
  endtask

  task automatic test_op_decode();
    // op == 0 is ignored.
    in_valid = 1'b1; op = 4'b0000; src1 = 32'd1; src2 = 32'd1;
    @(posedge clk); #1 in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL op_zero: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
    // multu outranks div.
    expect_res(32'h0000_0000, 32'h0000_0064, 1'b0, 2);
    drive(4'b0110, 32'd10, 32'd10);
    collect("prio_multu", 0);
    // div outranks divu: a signed result is required.
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
    drive(4'b1100, 32'hFFFF_FFF7, 32'd4);
    collect("prio_div", 0);
  endtask

  task automatic test_backpressure();
    expect_res(32'h0000_0000, 32'hA3D7_0A38, 1'b0, 2);
    drive(OP_MULTU, 32'h1234_5678, 32'd9);
    collect("backpressure", 5);
  endtask

  task automatic test_cancel();
    int seen;
    drive(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk); #1 cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL cancel_div: busy=%b in_ready=%b valid=%b, required 0 1 0",
               busy, in_ready, out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL cancel_quiet: out_valid seen %0d cycles, required 0", seen);
    end
    expect_res(32'h0000_0000, 32'h0000_000C, 1'b0, 2);
    drive(OP_MULTU, 32'd3, 32'd4);
    collect("after_cancel", 0);

    // Cancel in IDLE drops the request.
    in_valid = 1'b1; op = OP_MULT; src1 = 32'd2; src2 = 32'd2; cancel = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; cancel = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL cancel_idle: busy=%b, required 0", busy);
    end

    // Cancel beats out_ready in DONE.
    drive(OP_MULT, 32'd6, 32'd7);
    seen = 0;
    while (out_valid !== 1'b1 && seen < 100) begin
      @(posedge clk); #1; seen++;
    end
    cancel = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 cancel = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (seen != 2 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL cancel_done: wait=%0d valid=%b busy=%b, required 2 0 0",
               seen, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    drive(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_hi !== '0 || out_lo !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: busy=%b in_ready=%b valid=%b hi=%h lo=%h, required 0 1 0 0 0",
               busy, in_ready, out_valid, out_hi, out_lo);
    end
  endtask

  task automatic test_random();
    logic [3:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    for (int i = 0; i < 16; i++) begin
      o = 4'b0001 << $urandom_range(0, 3);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = '0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 50));
        3: b = -32'($urandom_range(1, 50));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 60));
      model(o, a, b, hi, lo, dbz, lat);
      expect_res(hi, lo, dbz, lat);
      drive(o, a, b);
      collect($sformatf("rand%0d", i), $urandom_range(0, 2));
    end
  endtask

  // Guard against a DUT that stalls the bench.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_op_decode();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
